// File: rtl/pwm_peripheral.sv
// Sixteen-channel output stage driven by one shared, prescaled 8-bit PWM waveform.
// Duty updates are shadowed and only take effect at the period wrap, so pulses are never truncated.
module pwm_peripheral #(
  parameter int PRESCALE = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start,
  output logic [7:0]  duty_active
);

  // A prescale of 1 still needs a one-bit counter so the compare below stays well-formed.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_cnt_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    duty_shadow_r;
  logic          tick_s;
  logic          wrap_s;
  logic          pwm_level_s;
  logic [15:0]   en_out_s;
  logic [15:0]   en_pwm_s;
  logic [15:0]   pwm_next_s;

  // Full-scale duty is treated as a constant high rather than 255/256.
  function automatic logic pwm_level_f(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) | (cnt < duty);
  endfunction

  // Tick, wrap and next-output decode from the current counter and enable state.
  always_comb begin
    tick_s      = (presc_cnt_r == PRESC_LAST);
    wrap_s      = tick_s & (pwm_cnt_r == 8'hFF);
    pwm_level_s = pwm_level_f(pwm_cnt_r, duty_shadow_r);
    en_out_s    = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm_s    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pwm_next_s  = en_out_s & (~en_pwm_s | {16{pwm_level_s}});
  end

  // Prescaler, PWM counter, duty shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_r   <= '0;
      pwm_cnt_r     <= 8'h00;
      duty_shadow_r <= 8'h00;
      period_start  <= 1'b0;
      pwm_out       <= 16'h0000;
    end else begin
      if (tick_s) begin
        presc_cnt_r <= '0;
        pwm_cnt_r   <= pwm_cnt_r + 8'd1;
      end else begin
        presc_cnt_r <= presc_cnt_r + PRESC_ONE;
        pwm_cnt_r   <= pwm_cnt_r;
      end
      if (wrap_s) begin
        duty_shadow_r <= pwm_duty_cycle;
      end else begin
        duty_shadow_r <= duty_shadow_r;
      end
      period_start <= wrap_s;
      pwm_out      <= pwm_next_s;
    end
  end

  assign duty_active = duty_shadow_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: one instance at PRESCALE=1, one at PRESCALE=4,
// sharing stimulus; expected values are hand-derived cycle counts and constants.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] pwm_out;
  logic        period_start;
  logic [7:0]  duty_active;
  logic [15:0] pwm_out4;
  logic        period_start4;
  logic [7:0]  duty_active4;

  int checks;
  int failures;
  int n_b0, n_b1, n_b2, n_b3, n_upper, n_rise0, n_ps, n_full, n_zero, n_split, n_diff02;
  int n4_b0, n4_rise, n4_ps;
  logic prev0;
  logic prev4;

  pwm_peripheral #(.PRESCALE(1)) dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .pwm_out(pwm_out), .period_start(period_start), .duty_active(duty_active)
  );

  pwm_peripheral #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .pwm_out(pwm_out4), .period_start(period_start4), .duty_active(duty_active4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_b0 = 0; n_b1 = 0; n_b2 = 0; n_b3 = 0; n_upper = 0; n_rise0 = 0; n_ps = 0;
    n_full = 0; n_zero = 0; n_split = 0; n_diff02 = 0;
    n4_b0 = 0; n4_rise = 0; n4_ps = 0;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out[0]) n_b0++;
      if (pwm_out[1]) n_b1++;
      if (pwm_out[2]) n_b2++;
      if (pwm_out[3]) n_b3++;
      if (pwm_out[15:4] != 12'h000) n_upper++;
      if (pwm_out[0] && !prev0) n_rise0++;
      prev0 = pwm_out[0];
      if (period_start) n_ps++;
      if (pwm_out == 16'hFFFF) n_full++;
      else if (pwm_out == 16'h0000) n_zero++;
      else n_split++;
      if (pwm_out[0] != pwm_out[2]) n_diff02++;
      if (pwm_out4[0]) n4_b0++;
      if (pwm_out4[0] && !prev4) n4_rise++;
      prev4 = pwm_out4[0];
      if (period_start4) n4_ps++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev0 = 1'b0;
    prev4 = 1'b0;
    clr();
    rst = 1'b1;
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle  = 8'h80;
    tick_n(2);
    check("reset_pwm_out", 32'(pwm_out), 32'h0000);
    check("reset_period_start", 32'(period_start), 32'h0);
    check("reset_duty_active", 32'(duty_active), 32'h00);

    // Duty 0x80: first period runs at duty 0, later periods 128 high / 128 low.
    rst = 1'b0;
    clr();
    tick_n(256);
    check("p1_high_cycles", 32'(n_b0), 32'd0);
    check("p1_zero_cycles", 32'(n_zero), 32'd256);
    check("p1_ps_pulses", 32'(n_ps), 32'd1);
    check("p1_ps_at_wrap", 32'(period_start), 32'h1);
    check("p1_duty_loaded", 32'(duty_active), 32'h80);
    clr();
    tick_n(256);
    check("p2_high_cycles", 32'(n_b0), 32'd128);
    check("p2_single_run", 32'(n_rise0), 32'd1);
    check("p2_full_cycles", 32'(n_full), 32'd128);
    check("p2_aligned", 32'(n_split), 32'd0);
    check("p2_ps_pulses", 32'(n_ps), 32'd1);
    check("p2_end_low", 32'(pwm_out), 32'h0000);
    clr();
    tick_n(256);
    check("p3_high_cycles", 32'(n_b0), 32'd128);
    check("p3_single_run", 32'(n_rise0), 32'd1);
    check("p3_ps_pulses", 32'(n_ps), 32'd1);
    check("p3_ps_at_wrap", 32'(period_start), 32'h1);

    // Duty 0x00 then 0xFF, each loaded at a wrap.
    pwm_duty_cycle = 8'h00;
    tick_n(256);
    clr();
    tick_n(256);
    check("duty00_zero_cycles", 32'(n_zero), 32'd256);
    check("duty00_active", 32'(duty_active), 32'h00);
    pwm_duty_cycle = 8'hFF;
    tick_n(256);
    check("dutyFF_active", 32'(duty_active), 32'hFF);
    clr();
    tick_n(512);
    check("dutyFF_full_cycles", 32'(n_full), 32'd512);
    check("dutyFF_ps_pulses", 32'(n_ps), 32'd2);

    // Mixed enables: bits 1,3 static high, bits 0,2 PWM, rest off.
    en_reg_out_7_0  = 8'h0F;
    en_reg_pwm_7_0  = 8'h05;
    en_reg_out_15_8 = 8'h00;
    pwm_duty_cycle  = 8'h40;
    tick_n(1);
    check("enable_next_cycle", 32'(pwm_out), 32'h000F);
    tick_n(255);
    clr();
    tick_n(256);
    check("mix_bit0_high", 32'(n_b0), 32'd64);
    check("mix_bit2_high", 32'(n_b2), 32'd64);
    check("mix_bit1_static", 32'(n_b1), 32'd256);
    check("mix_bit3_static", 32'(n_b3), 32'd256);
    check("mix_upper_off", 32'(n_upper), 32'd0);
    check("mix_bit0_bit2_aligned", 32'(n_diff02), 32'd0);

    // Duty change mid-period is deferred to the next wrap.
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    clr();
    tick_n(100);
    pwm_duty_cycle = 8'hC0;
    tick_n(155);
    check("shadow_hold_active", 32'(duty_active), 32'h40);
    check("shadow_hold_ps", 32'(period_start), 32'h0);
    tick_n(1);
    check("shadow_wrap_active", 32'(duty_active), 32'hC0);
    check("shadow_wrap_ps", 32'(period_start), 32'h1);
    check("shadow_old_high", 32'(n_b0), 32'd64);
    clr();
    tick_n(256);
    check("shadow_new_high", 32'(n_b0), 32'd192);
    check("shadow_new_aligned", 32'(n_split), 32'd0);

    // Reset at pwm_cnt=37 while outputs are high.
    tick_n(37);
    check("prereset_high", 32'(pwm_out), 32'hFFFF);
    rst = 1'b1;
    tick_n(1);
    check("midreset_pwm_out", 32'(pwm_out), 32'h0000);
    check("midreset_duty", 32'(duty_active), 32'h00);
    check("midreset_ps", 32'(period_start), 32'h0);
    rst = 1'b0;
    clr();
    tick_n(255);
    check("postreset_low", 32'(n_zero), 32'd255);
    check("postreset_no_ps", 32'(n_ps), 32'd0);
    tick_n(1);
    check("postreset_wrap_ps", 32'(period_start), 32'h1);
    check("postreset_wrap_duty", 32'(duty_active), 32'hC0);
    check("postreset_wrap_low", 32'(pwm_out), 32'h0000);
    tick_n(1);
    check("postreset_first_high", 32'(pwm_out), 32'hFFFF);

    // PRESCALE=4 instance, duty 0x02.
    pwm_duty_cycle = 8'h02;
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    clr();
    tick_n(1023);
    check("ps4_no_early_wrap", 32'(n4_ps), 32'd0);
    tick_n(1);
    check("ps4_wrap_1024", 32'(period_start4), 32'h1);
    check("ps4_duty_loaded", 32'(duty_active4), 32'h02);
    clr();
    tick_n(1024);
    check("ps4_high_cycles", 32'(n4_b0), 32'd8);
    check("ps4_single_run", 32'(n4_rise), 32'd1);
    check("ps4_ps_pulses", 32'(n4_ps), 32'd1);
    check("ps4_wrap_2048", 32'(period_start4), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
